// File: rtl/aes_dec_pkg.sv
// Shared AES inverse-cipher definitions: key-length codes, round counts,
// FSM states and GF(2^8) column/row helpers.
package aes_dec_pkg;
  localparam logic [1:0] KEYLEN_128 = 2'b00;
  localparam logic [1:0] KEYLEN_256 = 2'b01;
  localparam logic [1:0] KEYLEN_192 = 2'b10;
  localparam logic [1:0] KEYLEN_BAD = 2'b11;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_SBOX, ST_MAIN} state_t;

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      KEYLEN_256: return NR_256;
      KEYLEN_192: return NR_192;
      default:    return NR_128;
    endcase
  endfunction

  function automatic logic [7:0] gm2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm4(input logic [7:0] b);
    return gm2(gm2(b));
  endfunction
  function automatic logic [7:0] gm8(input logic [7:0] b);
    return gm2(gm4(b));
  endfunction
  function automatic logic [7:0] gm9(input logic [7:0] b);
    return gm8(b) ^ b;
  endfunction
  function automatic logic [7:0] gm11(input logic [7:0] b);
    return gm8(b) ^ gm2(b) ^ b;
  endfunction
  function automatic logic [7:0] gm13(input logic [7:0] b);
    return gm8(b) ^ gm4(b) ^ b;
  endfunction
  function automatic logic [7:0] gm14(input logic [7:0] b);
    return gm8(b) ^ gm4(b) ^ gm2(b);
  endfunction

  function automatic logic [31:0] inv_mixw(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gm14(a0) ^ gm11(a1) ^ gm13(a2) ^ gm9(a3),
            gm9(a0)  ^ gm14(a1) ^ gm11(a2) ^ gm13(a3),
            gm13(a0) ^ gm9(a1)  ^ gm14(a2) ^ gm11(a3),
            gm11(a0) ^ gm13(a1) ^ gm9(a2)  ^ gm14(a3)};
  endfunction

  function automatic logic [127:0] inv_mixcolumns(input logic [127:0] s);
    return {inv_mixw(s[127:96]), inv_mixw(s[95:64]), inv_mixw(s[63:32]), inv_mixw(s[31:0])};
  endfunction

  // Byte 0 is [127:120]; bytes are column-major, row r rotates right by r.
  function automatic logic [127:0] inv_shiftrows(input logic [127:0] s);
    logic [0:15][7:0] b, o;
    b = s;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[r + 4*c] = b[r + 4*((c - r + 4) % 4)];
    return o;
  endfunction
endpackage

// File: rtl/aes_decipher_block_p_sbox.sv
// 32-bit AES inverse S-box: inverse affine map followed by GF(2^8) inversion.
module aes_inv_sbox
  import aes_dec_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] sub_word
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = gm2(x);
    end
    return p;
  endfunction

  // x^254 gives the multiplicative inverse, with 0 mapping to 0.
  function automatic logic [7:0] inv_sbox8(input logic [7:0] x);
    logic [7:0] a, t, r;
    a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    t = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      t = gf_mul(t, t);
      r = gf_mul(r, t);
    end
    return r;
  endfunction

  always_comb begin
    sub_word = '0;
    for (int i = 0; i < 4; i++) sub_word[8*i +: 8] = inv_sbox8(word[8*i +: 8]);
  end
endmodule

// File: rtl/aes_decipher_block_p.sv
// Iterative AES-128/192/256 inverse-cipher round engine with SBOX_LANES
// inverse S-box words per cycle; round keys fetched by index via `round`.
module aes_decipher_block_p
  import aes_dec_pkg::*;
#(
  parameter int SBOX_LANES = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic         abort,
  input  logic [1:0]   keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready,
  output logic         done,
  output logic         keylen_err
);
  if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4)) begin : g_bad_lanes
    $error("SBOX_LANES must be 1, 2 or 4");
  end

  // With 4 lanes both wrap to 0, so the word counter stays constant.
  localparam logic [1:0] STEP = 2'(SBOX_LANES);
  localparam logic [1:0] LAST = 2'(4 - SBOX_LANES);

  state_t                          state;
  logic   [1:0]                    ctr;
  logic   [0:3][31:0]              st;
  logic   [SBOX_LANES-1:0][31:0]   sub_in, sub_out;

  assign new_block = st;

  for (genvar g = 0; g < SBOX_LANES; g++) begin : g_lane
    assign sub_in[g] = st[ctr + 2'(g)];
    aes_inv_sbox u_sbox (.word(sub_in[g]), .sub_word(sub_out[g]));
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state      <= ST_IDLE;
      ctr        <= 2'd0;
      st         <= '0;
      round      <= 4'd0;
      ready      <= 1'b1;
      done       <= 1'b0;
      keylen_err <= 1'b0;
    end else begin
      done       <= 1'b0;
      keylen_err <= 1'b0;
      case (state)
        ST_IDLE: if (next && !abort) begin
          if (keylen == KEYLEN_BAD) keylen_err <= 1'b1;
          else begin
            round <= nr_of(keylen);
            ready <= 1'b0;
            state <= ST_INIT;
          end
        end
        ST_INIT: begin
          st    <= inv_shiftrows(block ^ round_key);
          ctr   <= 2'd0;
          state <= ST_SBOX;
        end
        ST_SBOX: begin
          for (int l = 0; l < SBOX_LANES; l++) st[ctr + 2'(l)] <= sub_out[l];
          ctr <= ctr + STEP;
          if (ctr == LAST) begin
            round <= round - 4'd1;
            state <= ST_MAIN;
          end
        end
        default: begin
          ctr <= 2'd0;
          if (round != 4'd0) begin
            st    <= inv_shiftrows(inv_mixcolumns(st ^ round_key));
            state <= ST_SBOX;
          end else begin
            st    <= st ^ round_key;
            ready <= 1'b1;
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
      endcase
      // Cancel overrides whatever the current state scheduled.
      if (abort && state != ST_IDLE) begin
        state <= ST_IDLE;
        ready <= 1'b1;
        done  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_aes_decipher_block_p.sv
// Scoreboard bench: 1-, 2- and 4-lane engines run side by side against
// FIPS-197 vectors, with round keys from a bench key-schedule model.
module tb_aes_decipher_block_p;
  localparam int LN [3] = '{1, 2, 4};
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

  typedef struct {
    logic [127:0] pt;
    int           lat;
    int           st;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         next = 1'b0, abort = 1'b0;
  logic [1:0]   keylen = 2'b00;
  logic [127:0] blk = '0;
  logic [3:0]   rnd  [3];
  logic [127:0] rkey [3];
  logic [127:0] nb   [3];
  logic         rdy  [3];
  logic         dn   [3];
  logic         kerr [3];

  logic [127:0] rk [16];
  logic [7:0]   sb_tab [256];
  exp_t         sb [3][$];
  exp_t         mon_e;
  int           cyc = 0, st_cyc = 0;
  int           n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign rkey[g] = rk[rnd[g]];
    aes_decipher_block_p #(.SBOX_LANES(LN[g])) u_dut (
      .clk(clk), .reset_n(rst), .next(next), .abort(abort), .keylen(keylen),
      .round(rnd[g]), .round_key(rkey[g]), .block(blk), .new_block(nb[g]),
      .ready(rdy[g]), .done(dn[g]), .keylen_err(kerr[g]));
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xt(a);
    end
    return p;
  endfunction

  // Forward S-box table: brute-force inverse, then the forward affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00, b;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sb_tab[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb_tab[w[31:24]], sb_tab[w[23:16]], sb_tab[w[15:8]], sb_tab[w[7:0]]};
  endfunction

  // Key 00 01 02 ... of nk words, expanded into rk[0..nk+6].
  task automatic load_key(input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    int          nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) rk[r] = '0;
    for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Caller sits at a negedge; returns just after the sampling edge.
  task automatic start(input logic [1:0] kl, input int nk, input logic [127:0] ct, input bit push);
    exp_t e;
    load_key(nk);
    keylen = kl;
    blk    = ct;
    next   = 1'b1;
    @(posedge clk);
    #1 next = 1'b0;
    st_cyc = cyc;
    if (push)
      for (int g = 0; g < 3; g++) begin
        e.pt  = PT;
        e.lat = 1 + (nk + 6) * (4 / LN[g] + 1);
        e.st  = st_cyc;
        sb[g].push_back(e);
      end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      chk("timeout", 128'(sb[0].size() + sb[1].size() + sb[2].size()), 128'd0);
      for (int g = 0; g < 3; g++) sb[g].delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk)
    for (int g = 0; g < 3; g++)
      if (dn[g] === 1'b1) begin
        if (sb[g].size() == 0) chk($sformatf("spurious_done_l%0d", LN[g]), 128'd1, 128'd0);
        else begin
          mon_e = sb[g].pop_front();
          chk($sformatf("pt_l%0d", LN[g]), nb[g], mon_e.pt);
          chk($sformatf("lat_l%0d", LN[g]), 128'(cyc - mon_e.st), 128'(mon_e.lat));
          chk($sformatf("rdy_at_done_l%0d", LN[g]), 128'(rdy[g]), 128'd1);
        end
      end

  task automatic chk_reset_vals(input string tag);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s_nb_l%0d", tag, LN[g]), nb[g], 128'd0);
      chk($sformatf("%s_round_l%0d", tag, LN[g]), 128'(rnd[g]), 128'd0);
      chk($sformatf("%s_ready_l%0d", tag, LN[g]), 128'(rdy[g]), 128'd1);
      chk($sformatf("%s_done_l%0d", tag, LN[g]), 128'(dn[g]), 128'd0);
      chk($sformatf("%s_kerr_l%0d", tag, LN[g]), 128'(kerr[g]), 128'd0);
    end
  endtask

  initial begin
    build_sbox();
    load_key(4);
    #12 chk_reset_vals("reset");
    @(negedge clk) rst = 1'b0;
    @(negedge clk);

    // AES-128, then AES-192 with keylen changed mid-run, then AES-256.
    start(2'b00, 4, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1);
    wait_idle(200);
    start(2'b10, 6, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 1'b1);
    keylen = 2'b00;
    wait_idle(200);
    start(2'b01, 8, 128'h8ea2b7ca516745bfeafc49904b496089, 1'b1);
    wait_idle(200);

    // Illegal key length in IDLE.
    keylen = 2'b11;
    next   = 1'b1;
    @(negedge clk) next = 1'b0;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("kerr_pulse_l%0d", LN[g]), 128'(kerr[g]), 128'd1);
      chk($sformatf("kerr_ready_l%0d", LN[g]), 128'(rdy[g]), 128'd1);
      chk($sformatf("kerr_round_l%0d", LN[g]), 128'(rnd[g]), 128'd0);
      chk($sformatf("kerr_nb_l%0d", LN[g]), nb[g], PT);
    end
    @(negedge clk);
    for (int g = 0; g < 3; g++) chk($sformatf("kerr_once_l%0d", LN[g]), 128'(kerr[g]), 128'd0);

    // next + abort together in IDLE: nothing starts, no error.
    next = 1'b1; abort = 1'b1;
    @(negedge clk) begin next = 1'b0; abort = 1'b0; end
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("abort_wins_kerr_l%0d", LN[g]), 128'(kerr[g]), 128'd0);
      chk($sformatf("abort_wins_ready_l%0d", LN[g]), 128'(rdy[g]), 128'd1);
    end
    keylen = 2'b00;
    next = 1'b1; abort = 1'b1;
    @(negedge clk) begin next = 1'b0; abort = 1'b0; end
    for (int g = 0; g < 3; g++) chk($sformatf("abort_wins_idle_l%0d", LN[g]), 128'(rdy[g]), 128'd1);

    // Abort at cycle 20 of AES-128, with an ignored busy start before it.
    start(2'b00, 4, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0);
    repeat (3) @(negedge clk);
    keylen = 2'b11; next = 1'b1;
    @(negedge clk) begin next = 1'b0; keylen = 2'b00; end
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("busy_next_kerr_l%0d", LN[g]), 128'(kerr[g]), 128'd0);
      chk($sformatf("busy_ready_l%0d", LN[g]), 128'(rdy[g]), 128'd0);
    end
    while (cyc < st_cyc + 19) @(negedge clk);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("abort_ready_l%0d", LN[g]), 128'(rdy[g]), 128'd1);
      chk($sformatf("abort_done_l%0d", LN[g]), 128'(dn[g]), 128'd0);
    end
    start(2'b00, 4, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1);
    wait_idle(200);

    // Asynchronous reset mid-round, then a clean AES-128 run.
    @(negedge clk);
    start(2'b01, 8, 128'h8ea2b7ca516745bfeafc49904b496089, 1'b1);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_reset_vals("async_rst");
    for (int g = 0; g < 3; g++) sb[g].delete();
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    start(2'b00, 4, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1);
    wait_idle(200);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/aes_decipher_block_p.md
# aes_decipher_block_p

Parametrised, iterative AES inverse-cipher round engine: the next-generation decipher datapath supporting AES-128, AES-192 and AES-256. The number of inverse S-box lanes per cycle is configurable, so area and latency can be traded per instance. It adds a one-cycle `done` pulse, synchronous `abort` and illegal-key-length reporting. It sits between the core control FSM and the shared key-memory. It requests round keys by index via `round` and expects `round_key` to be combinationally valid for that index in the same cycle.

## Interface
- `SBOX_LANES`, default 1: number of 32-bit inverse S-box words processed per cycle. Legal values are 1, 2, 4; any other value is an elaboration error.
- `clk`  in  1: the single clock. All registers update on the rising edge.
- `reset_n`  in  1: asynchronous, active-high reset. The port keeps the codebase name `reset_n`; polarity is high.
- `next`  in  1: start request, sampled only in IDLE.
- `abort`  in  1: synchronous cancel of an operation in progress.
- `keylen`  in  2: key-length select. 2'b00 = 128, 2'b01 = 256, 2'b10 = 192, 2'b11 = illegal.
- `round`  out  4: index of the round key requested this cycle.
- `round_key`  in  128: key for index `round`.
- `block`  in  128: ciphertext, sampled in the INIT cycle.
- `new_block`  out  128: state register; holds the plaintext after completion.
- `ready`  out  1: high when idle.
- `done`  out  1: one-cycle pulse when a result is valid.
- `keylen_err`  out  1: one-cycle pulse when `next` arrives with an illegal `keylen`.

## Operation
- Number of rounds Nr is 10, 12 or 14 for keylen 00, 10, 01 respectively.
- S = 4/SBOX_LANES is the number of S-box cycles per round.
- The FSM has four states: IDLE, INIT, SBOX, MAIN.
- IDLE:
  - `next`=1, legal `keylen`, `abort`=0: `round` ← Nr, `ready` ← 0, go to INIT.
  - `next`=1 with keylen 11: `keylen_err` ← 1 for one cycle; state, `ready` and `new_block` are unchanged.
- INIT:
  - state ← InvShiftRows(`block` ^ `round_key`).
  - Word counter ← 0; go to SBOX.
- SBOX:
  - Words ctr..ctr+SBOX_LANES-1 are replaced by their InvSubBytes value; word 0 is bits [127:96].
  - Counter ← counter + SBOX_LANES.
  - On the last group: `round` ← `round` - 1, go to MAIN.
- MAIN:
  - Word counter ← 0.
  - If `round` > 0: state ← InvShiftRows(InvMixColumns(state ^ `round_key`)), go to SBOX.
  - Otherwise: state ← state ^ `round_key`, `ready` ← 1, `done` ← 1, go to IDLE.
- `abort`=1 in any non-IDLE state: next edge forces IDLE and `ready` ← 1. `done` is not pulsed. `new_block` keeps its partial contents, which are not valid.
- `next` in a non-IDLE state is ignored.
- `keylen` is sampled only on the start edge. `round` runs from the latched Nr, so later changes to `keylen` have no effect.
- `next` and `abort` together in IDLE: abort wins, the start is ignored, and there is no `keylen_err`.

## Timing
- Reset values: `new_block` = 0, `round` = 0, `ready` = 1, `done` = 0, `keylen_err` = 0, state IDLE, word counter 0.
- Reset applied mid-operation returns the block to reset values immediately, without waiting for a clock edge.
- Latency from the edge sampling `next` to the edge where `ready`/`done` rise is 1 + Nr·(S+1) cycles. Examples:
  - AES-128, 1 lane: 51 cycles.
  - AES-256, 4 lanes: 29 cycles.
- `done` is high for exactly the cycle after the final update. `new_block` stays stable until the next INIT.
- The earliest back-to-back start is `next` sampled in the first cycle `ready`=1.
- `round` value per state: Nr during INIT, the current round during MAIN, 0 during the final update.

## Structure
- Shared package `aes_dec_pkg` holds:
  - keylen encodings;
  - round counts (10/12/14);
  - FSM state encodings;
  - GF(2^8) helpers gm2…gm14, inv_mixw, inv_shiftrows.
- Sub-module: `aes_inv_sbox` (existing 32-bit inverse S-box), instantiated SBOX_LANES times through a generate loop.
- The word counter is 2 bits and increments by SBOX_LANES; with 4 lanes it is constant 0.

## Test plan
Round keys come from a reference key-schedule model in the bench, driven combinationally from `round`.
- AES-128, key 000102…0f, `block` 69c4e0d86a7b0430d8cdb78070b4c55a: `new_block` = 00112233445566778899aabbccddeeff and `done` 51 cycles after `next`. Repeat for SBOX_LANES 2 and 4, expecting 31 and 21 cycles.
- AES-192, key 000102…17, `block` dda97ca4864cdfe06eaf70a0ec0d7191: same plaintext, 61 cycles at 1 lane.
- AES-256, key 000102…1f, `block` 8ea2b7ca516745bfeafc49904b496089: same plaintext, 71 cycles at 1 lane, 29 at 4 lanes.
- `keylen`=11 with `next`: `keylen_err` pulses once; `ready` stays 1 and `round` stays 0.
- `abort` at cycle 20 of AES-128: `ready`=1 next cycle, no `done`. An immediate restart decrypts correctly. `next` pulsed while busy has no effect.
- `reset_n` asserted mid-round, asynchronous to `clk`: outputs take their reset values before the next edge; a following AES-128 run passes.
